// File: rtl/vga_fb_scheduler.sv
// vga_fb_scheduler: shares one framebuffer port between the per-line fetch
// into the line buffer and PPU writes. A fetch of NES line n copies 256
// pixels from the framebuffer into the back line-buffer bank, one scanline
// pair ahead of display.
// Optional build macro FB_SCHED_RR_EN: round-robin fetch/PPU arbitration
// under contention. When it is undefined, the fetch has fixed priority.
module vga_fb_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        ppu_wr_req,
    input  logic [15:0] ppu_wr_addr,
    input  logic [5:0]  ppu_wr_data,
    output logic        ppu_wr_ack,
    output logic [15:0] fb_addr,
    output logic        fb_we,
    output logic [5:0]  fb_wdata,
    input  logic [5:0]  fb_rdata,
    output logic        lb_we,
    output logic [7:0]  lb_addr,
    output logic [5:0]  lb_wdata,
    output logic        lb_bank,
    output logic        fetch_overrun
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0] state;
    logic [7:0] line;
    logic [7:0] col;
    logic       rd_pend;
    logic [7:0] rd_col;

    logic [9:0] v_next;
    logic [8:0] next_line;
    logic       trigger;
    logic       toggle;
    logic       start_fetch;
    logic [7:0] start_line;

    logic       fetch_rq;
    logic       ppu_rq;
    logic       grant_fetch;
    logic       grant_ppu;

`ifdef FB_SCHED_RR_EN
    logic       rr_ppu;
`endif

    // Decode the end-of-line trigger into bank toggle and fetch start
    always_comb begin
        v_next      = (v_cnt == 10'd524) ? '0 : v_cnt + 10'd1;
        next_line   = v_next[9:1] + 9'd1;
        trigger     = en && (h_cnt == 10'd799);
        toggle      = 1'b0;
        start_fetch = 1'b0;
        start_line  = '0;
        if (trigger) begin
            if (v_next == 10'd523) begin
                start_fetch = 1'b1;
            end else if (!v_next[0] && (v_next < 10'd480)) begin
                toggle = 1'b1;
                if (next_line <= 9'd239) begin
                    start_fetch = 1'b1;
                    start_line  = next_line[7:0];
                end
            end
        end
    end

    // Framebuffer port arbitration; a PPU request is ignored in its ack cycle
    always_comb begin
        fetch_rq = (state == FETCH);
        ppu_rq   = ppu_wr_req && !ppu_wr_ack;
`ifdef FB_SCHED_RR_EN
        grant_fetch = fetch_rq && (!ppu_rq || !rr_ppu);
`else
        grant_fetch = fetch_rq;
`endif
        grant_ppu = ppu_rq && !grant_fetch;
    end

`ifdef FB_SCHED_RR_EN
    // Round-robin pointer: after a fetch grant favour the PPU and vice versa
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ppu <= 1'b0;
        end else if (grant_fetch) begin
            rr_ppu <= 1'b1;
        end else if (grant_ppu) begin
            rr_ppu <= 1'b0;
        end
    end
`endif

    // Fetch FSM; a fetch start later in the block overrides DRAIN/IDLE moves
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            line  <= '0;
            col   <= '0;
        end else begin
            if (grant_fetch) begin
                col <= col + 8'd1;
                if (col == 8'hFF) begin
                    state <= DRAIN;
                end
            end
            if ((state == DRAIN) && !rd_pend && lb_we) begin
                state <= IDLE;
            end
            if (start_fetch) begin
                state <= FETCH;
                line  <= start_line;
                col   <= '0;
            end
        end
    end

    // Framebuffer port registers and PPU acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_addr    <= '0;
            fb_wdata   <= '0;
            fb_we      <= 1'b0;
            ppu_wr_ack <= 1'b0;
        end else begin
            fb_we      <= 1'b0;
            ppu_wr_ack <= 1'b0;
            if (grant_fetch) begin
                fb_addr <= {line, col};
            end else if (grant_ppu) begin
                fb_addr    <= ppu_wr_addr;
                fb_wdata   <= ppu_wr_data;
                fb_we      <= 1'b1;
                ppu_wr_ack <= 1'b1;
            end
        end
    end

    // Read pipeline: read issued, then line-buffer write when data returns
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend <= 1'b0;
            rd_col  <= '0;
            lb_we   <= 1'b0;
            lb_addr <= '0;
        end else begin
            rd_pend <= grant_fetch;
            if (grant_fetch) begin
                rd_col <= col;
            end
            lb_we <= rd_pend;
            if (rd_pend) begin
                lb_addr <= rd_col;
            end
        end
    end

    // Line-buffer data comes straight from the framebuffer read port
    always_comb begin
        lb_wdata = lb_we ? fb_rdata : '0;
    end

    // Display bank selection and sticky overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            lb_bank       <= 1'b0;
            fetch_overrun <= 1'b0;
        end else begin
            if (toggle) begin
                lb_bank <= ~lb_bank;
            end
            if (start_fetch && (state != IDLE)) begin
                fetch_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// tb_vga_fb_scheduler: directed bench for vga_fb_scheduler with a
// synchronous-read framebuffer model and a simple holding PPU requester.
module tb_vga_fb_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        ppu_wr_req;
    logic [15:0] ppu_wr_addr;
    logic [5:0]  ppu_wr_data;
    logic        ppu_wr_ack;
    logic [15:0] fb_addr;
    logic        fb_we;
    logic [5:0]  fb_wdata;
    logic [5:0]  fb_rdata = '0;
    logic        lb_we;
    logic [7:0]  lb_addr;
    logic [5:0]  lb_wdata;
    logic        lb_bank;
    logic        fetch_overrun;

    vga_fb_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .h_cnt         (h_cnt),
        .v_cnt         (v_cnt),
        .ppu_wr_req    (ppu_wr_req),
        .ppu_wr_addr   (ppu_wr_addr),
        .ppu_wr_data   (ppu_wr_data),
        .ppu_wr_ack    (ppu_wr_ack),
        .fb_addr       (fb_addr),
        .fb_we         (fb_we),
        .fb_wdata      (fb_wdata),
        .fb_rdata      (fb_rdata),
        .lb_we         (lb_we),
        .lb_addr       (lb_addr),
        .lb_wdata      (lb_wdata),
        .lb_bank       (lb_bank),
        .fetch_overrun (fetch_overrun)
    );

    always #5 clk = ~clk;

    // Framebuffer content is a fixed function of the address
    function automatic logic [5:0] fb_fn(input logic [15:0] a);
        return a[5:0] ^ a[11:6] ^ {2'b00, a[15:12]};
    endfunction

    // Synchronous read: data valid the cycle after the address is presented
    always @(posedge clk) fb_rdata <= fb_fn(fb_addr);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-run observations
    int          lb_cnt, lb_bad, lb_k, lb_cnt_a;
    int          ack_cnt, ack_dbl, ppu_bad, first_ack_c, last_lb_c, rd_bad;
    logic        prev_ack;
    logic [15:0] addr_c2;
    logic [7:0]  cur_ln;
    logic        seq_chk;
    int          inject_c;
    logic [9:0]  inject_v;
    logic [7:0]  inject_ln;
    int          ppu_on_c;
    int          ppu_n;

    // Apply one end-of-line trigger at the current negedge and observe n cycles
    task automatic run(input logic [9:0] v, input logic en_t, input logic [7:0] ln, input int n);
        lb_cnt = 0; lb_bad = 0; lb_k = 0; lb_cnt_a = 0;
        ack_cnt = 0; ack_dbl = 0; ppu_bad = 0; first_ack_c = -1; last_lb_c = -1; rd_bad = 0;
        prev_ack = 1'b0; cur_ln = ln; addr_c2 = '0;
        h_cnt = 10'd799; v_cnt = v; en = en_t;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == 1) begin h_cnt = '0; en = 1'b0; end
            if (c == inject_c) begin h_cnt = 10'd799; v_cnt = inject_v; en = 1'b1; end
            if (c == inject_c + 1) begin h_cnt = '0; en = 1'b0; end
            if (c == inject_c + 3) begin lb_cnt_a = lb_cnt; lb_k = 0; cur_ln = inject_ln; end
            if (c == 2) addr_c2 = fb_addr;
            if (seq_chk && c >= 2 && c <= 257 && (fb_we || fb_addr != {ln, 8'(c - 2)}))
                rd_bad++;
            if (lb_we) begin
                if (lb_addr != 8'(lb_k) || lb_wdata != fb_fn({cur_ln, 8'(lb_k)}))
                    lb_bad++;
                lb_k++;
                lb_cnt++;
                last_lb_c = c;
            end
            if (ppu_wr_ack) begin
                if (!fb_we || fb_addr != ppu_wr_addr || fb_wdata != ppu_wr_data)
                    ppu_bad++;
                if (prev_ack) ack_dbl++;
                if (first_ack_c < 0) first_ack_c = c;
                ack_cnt++;
                ppu_n++;
                ppu_wr_addr = 16'h8000 + 16'(ppu_n);
                ppu_wr_data = 6'(ppu_n * 7);
            end else if (fb_we) begin
                ppu_bad++;
            end
            prev_ack = ppu_wr_ack;
            if (c == ppu_on_c) ppu_wr_req = 1'b1;
        end
        ppu_wr_req = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b0; h_cnt = '0; v_cnt = '0;
        ppu_wr_req = 1'b0; ppu_wr_addr = '0; ppu_wr_data = '0;
        seq_chk = 1'b0; inject_c = -10; inject_v = '0; inject_ln = '0;
        ppu_on_c = 0; ppu_n = 0;
        repeat (3) @(negedge clk);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_we", fb_we, 0);
        check("rst_fb_wdata", fb_wdata, 0);
        check("rst_lb_we", lb_we, 0);
        check("rst_lb_addr", lb_addr, 0);
        check("rst_lb_wdata", lb_wdata, 0);
        check("rst_ack", ppu_wr_ack, 0);
        check("rst_bank", lb_bank, 0);
        check("rst_overrun", fetch_overrun, 0);
        rst = 1'b0;
        @(negedge clk);

        // Pre-frame fetch of line 0, bank unchanged
        seq_chk = 1'b1;
        run(10'd522, 1'b1, 8'd0, 300);
        check("l0_rd_seq", rd_bad, 0);
        check("l0_lb_cnt", lb_cnt, 256);
        check("l0_lb_data", lb_bad, 0);
        check("l0_last_lb", last_lb_c, 258);
        check("l0_bank", lb_bank, 0);
        check("l0_fb_hold", fb_addr, 16'h00FF);
        check("l0_fb_we", ppu_bad, 0);

        // v_next = 0: toggle and fetch line 1
        run(10'd524, 1'b1, 8'd1, 300);
        check("l1_first_addr", addr_c2, 16'h0100);
        check("l1_rd_seq", rd_bad, 0);
        check("l1_lb_cnt", lb_cnt, 256);
        check("l1_lb_data", lb_bad, 0);
        check("l1_bank", lb_bank, 1);
        check("l1_fb_hold", fb_addr, 16'h01FF);

        // v_next = 478: toggle only, line 240 out of range
        seq_chk = 1'b0;
        run(10'd477, 1'b1, 8'd0, 20);
        check("l240_lb_cnt", lb_cnt, 0);
        check("l240_bank", lb_bank, 0);
        check("l240_fb_hold", fb_addr, 16'h01FF);

        // v_next = 476: last fetched line 239
        seq_chk = 1'b1;
        run(10'd475, 1'b1, 8'd239, 300);
        check("l239_first_addr", addr_c2, 16'hEF00);
        check("l239_rd_seq", rd_bad, 0);
        check("l239_lb_cnt", lb_cnt, 256);
        check("l239_lb_data", lb_bad, 0);
        check("l239_bank", lb_bank, 1);
        seq_chk = 1'b0;

        // Non-triggers: odd v_next, v_next = 480, en low
        run(10'd478, 1'b1, 8'd0, 10);
        check("odd_lb_cnt", lb_cnt, 0);
        check("odd_bank", lb_bank, 1);
        run(10'd479, 1'b1, 8'd0, 10);
        check("v480_lb_cnt", lb_cnt, 0);
        check("v480_bank", lb_bank, 1);
        run(10'd524, 1'b0, 8'd0, 10);
        check("en0_lb_cnt", lb_cnt, 0);
        check("en0_bank", lb_bank, 1);
        check("idle_fb_hold", fb_addr, 16'hEFFF);

        // Lone PPU request is granted at once
        ppu_wr_addr = 16'h1234; ppu_wr_data = 6'h2A; ppu_wr_req = 1'b1;
        @(negedge clk);
        check("lone_ack", ppu_wr_ack, 1);
        check("lone_we", fb_we, 1);
        check("lone_addr", fb_addr, 16'h1234);
        check("lone_wdata", fb_wdata, 6'h2A);
        ppu_wr_req = 1'b0;
        @(negedge clk);
        check("lone_ack_off", ppu_wr_ack, 0);
        check("lone_we_off", fb_we, 0);
        check("lone_addr_hold", fb_addr, 16'h1234);

        // Contention: PPU held from the first FETCH cycle
        ppu_n = 0; ppu_wr_addr = 16'h8000; ppu_wr_data = '0; ppu_on_c = 1;
`ifdef FB_SCHED_RR_EN
        run(10'd522, 1'b1, 8'd0, 520);
        check("rr_first_ack", first_ack_c, 3);
        check("rr_last_lb", last_lb_c, 513);
        check("rr_ack_cnt", ack_cnt, 259);
`else
        run(10'd522, 1'b1, 8'd0, 300);
        check("fp_first_ack", first_ack_c, 258);
        check("fp_last_lb", last_lb_c, 258);
        check("fp_ack_cnt", ack_cnt, 22);
`endif
        check("arb_lb_cnt", lb_cnt, 256);
        check("arb_lb_data", lb_bad, 0);
        check("arb_ack_dbl", ack_dbl, 0);
        check("arb_ppu_wr", ppu_bad, 0);
        ppu_on_c = 0;

        // Overrun: second fetch start 100 cycles into line 1
        check("ovr_before", fetch_overrun, 0);
        inject_c = 100; inject_v = 10'd1; inject_ln = 8'd2;
        run(10'd524, 1'b1, 8'd1, 400);
        inject_c = -10;
        check("ovr_flag", fetch_overrun, 1);
        check("ovr_old_lb", lb_cnt_a, 100);
        check("ovr_new_lb", lb_cnt - lb_cnt_a, 256);
        check("ovr_lb_data", lb_bad, 0);
        check("ovr_fb_hold", fb_addr, 16'h02FF);
        check("ovr_bank", lb_bank, 1);

        // Sticky across a clean fetch; reset mid-fetch clears it and stops writes
        run(10'd522, 1'b1, 8'd0, 50);
        check("ovr_sticky", fetch_overrun, 1);
        check("mid_lb_cnt", lb_cnt, 48);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_lb_we", lb_we, 0);
        check("mrst_overrun", fetch_overrun, 0);
        check("mrst_bank", lb_bank, 0);
        rst = 1'b0;
        run(10'd0, 1'b0, 8'd0, 20);
        check("mrst_no_lb", lb_cnt, 0);
        check("mrst_fb_addr", fb_addr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
